// File: rtl/raster_line_scanner_if.sv
// Scanner-side bundle: sync inputs, framebuffer read port 2, laser outputs and status.
// master = scanner; slave = environment (framebuffer, photodiode, galvo, DAC).
interface raster_line_scanner_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              enable;
  logic              line_sync;
  logic              frame_sync;
  logic              overrun_clear;
  logic [ADDR_W-1:0] fb_address;
  logic              fb_chipselect;
  logic              fb_clken;
  logic              fb_write;
  logic [DATA_W-1:0] fb_readdata;
  logic [DATA_W-1:0] laser_level;
  logic              laser_on;
  logic [8:0]        line_index;
  logic              frame_start;
  logic              line_overrun;

  modport master (
    input  enable, line_sync, frame_sync, overrun_clear, fb_readdata,
    output fb_address, fb_chipselect, fb_clken, fb_write,
    output laser_level, laser_on, line_index, frame_start, line_overrun
  );

  modport slave (
    output enable, line_sync, frame_sync, overrun_clear, fb_readdata,
    input  fb_address, fb_chipselect, fb_clken, fb_write,
    input  laser_level, laser_on, line_index, frame_start, line_overrun
  );
endinterface

// File: rtl/raster_line_scanner.sv
// Streams one framebuffer scanline per mirror sync as laser intensity, PIX_DIV clocks per pixel.
// First address H_OFFSET+1 clks after the detected edge, pixel 2 clks after its address; no backpressure, a new sync aborts the line.
module raster_line_scanner #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int PIX_DIV  = 4,
  parameter int H_OFFSET = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  raster_line_scanner_if.master s_if
);
  localparam int PX_W  = $clog2(H_PIXELS);
  localparam int DIV_W = $clog2(PIX_DIV);
  localparam int POR_W = (H_OFFSET > 1) ? $clog2(H_OFFSET) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SYNC, S_PORCH, S_ACTIVE} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_ls_sync;
  logic [2:0]        r_fs_sync;
  logic              w_line_edge, w_frame_edge;
  logic              r_pending_frame;
  logic [POR_W-1:0]  r_porch, w_porch_nxt;
  logic [PX_W-1:0]   r_px, w_px_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [ADDR_W-1:0] r_line_base;
  logic [8:0]        r_line_index;
  logic              w_advance, w_overrun, w_issue, w_flush;
  logic              r_rd_vld;
  logic [DATA_W-1:0] r_laser_level;
  logic              r_laser_on;
  logic [DIV_W-1:0]  r_hold;
  logic              r_line_overrun;

  // line_sync: s1,s2,s3 in bits 0..2; frame_sync: 2-flop sync plus one history flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ls_sync <= '0;
      r_fs_sync <= '0;
    end else begin
      r_ls_sync <= {r_ls_sync[1:0], s_if.line_sync};
      r_fs_sync <= {r_fs_sync[1:0], s_if.frame_sync};
    end
  end

  assign w_line_edge  = r_ls_sync[1] & ~r_ls_sync[2];
  assign w_frame_edge = r_fs_sync[1] & ~r_fs_sync[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_porch <= '0;
      r_px    <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_porch <= w_porch_nxt;
      r_px    <= w_px_nxt;
      r_div   <= w_div_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_porch_nxt = r_porch;
    w_px_nxt    = r_px;
    w_div_nxt   = r_div;
    w_advance   = 1'b0;
    w_overrun   = 1'b0;
    if (!s_if.enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_WAIT_SYNC;
        S_WAIT_SYNC: begin
          if (w_line_edge) begin
            w_state_nxt = S_PORCH;
            w_porch_nxt = POR_W'(H_OFFSET - 1);
          end
        end
        S_PORCH, S_ACTIVE: begin
          if (w_line_edge) begin
            // Sync arrived before the line finished: abort, count the line, restart porch
            w_overrun   = 1'b1;
            w_advance   = 1'b1;
            w_state_nxt = S_PORCH;
            w_porch_nxt = POR_W'(H_OFFSET - 1);
          end else if (r_state == S_PORCH) begin
            if (r_porch == '0) begin
              w_state_nxt = S_ACTIVE;
              w_px_nxt    = '0;
              w_div_nxt   = '0;
            end else begin
              w_porch_nxt = r_porch - 1'b1;
            end
          end else if (r_div == DIV_W'(PIX_DIV - 1)) begin
            w_div_nxt = '0;
            if (r_px == PX_W'(H_PIXELS - 1)) begin
              w_state_nxt = S_WAIT_SYNC;
              w_advance   = 1'b1;
            end else begin
              w_px_nxt = r_px + 1'b1;
            end
          end else begin
            w_div_nxt = r_div + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_index    <= '0;
      r_line_base     <= '0;
      r_pending_frame <= 1'b0;
      r_line_overrun  <= 1'b0;
    end else begin
      if (w_advance) begin
        if (r_pending_frame || r_line_index == 9'(V_LINES - 1)) begin
          r_line_index <= '0;
          r_line_base  <= '0;
        end else begin
          r_line_index <= r_line_index + 1'b1;
          r_line_base  <= r_line_base + ADDR_W'(H_PIXELS);
        end
      end
      if (w_frame_edge)   r_pending_frame <= 1'b1;
      else if (w_advance) r_pending_frame <= 1'b0;
      if (w_overrun)               r_line_overrun <= 1'b1;
      else if (s_if.overrun_clear) r_line_overrun <= 1'b0;
    end
  end

  assign w_issue = (r_state == S_ACTIVE) && (r_div == '0);
  assign w_flush = w_overrun | ~s_if.enable;

  // r_hold counts the remaining display clocks of the current pixel so the last one is not cut short
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_vld      <= 1'b0;
      r_laser_level <= '0;
      r_laser_on    <= 1'b0;
      r_hold        <= '0;
    end else begin
      r_rd_vld <= w_issue & ~w_flush;
      if (w_flush) begin
        r_laser_level <= '0;
        r_laser_on    <= 1'b0;
        r_hold        <= '0;
      end else if (r_rd_vld) begin
        r_laser_level <= s_if.fb_readdata;
        r_laser_on    <= 1'b1;
        r_hold        <= DIV_W'(PIX_DIV - 1);
      end else if (r_laser_on) begin
        if (r_hold == '0) begin
          r_laser_level <= '0;
          r_laser_on    <= 1'b0;
        end else begin
          r_hold <= r_hold - 1'b1;
        end
      end
    end
  end

  assign s_if.fb_address    = w_issue ? (r_line_base + ADDR_W'(r_px)) : '0;
  assign s_if.fb_chipselect = w_issue;
  assign s_if.fb_clken      = w_issue;
  assign s_if.fb_write      = 1'b0;
  assign s_if.laser_level   = r_laser_level;
  assign s_if.laser_on      = r_laser_on;
  assign s_if.line_index    = r_line_index;
  assign s_if.frame_start   = w_issue && (r_px == '0) && (r_line_index == '0);
  assign s_if.line_overrun  = r_line_overrun;
endmodule

// File: tb/tb_raster_line_scanner.sv
// Directed bench for raster_line_scanner with a 1-clk registered RAM whose content is addr[7:0].
module tb_raster_line_scanner;
  localparam int H    = 640;
  localparam int PD   = 4;
  localparam int HOFF = 2;
  localparam int T0   = 3 + HOFF;            // first issue, clks after line_sync driven high
  localparam int TLI  = T0 + PD * (H - 1);   // last issue
  localparam int TON0 = T0 + 2;              // first pixel visible
  localparam int TON1 = T0 + PD * H + 1;     // last pixel's final clock
  localparam int TADV = T0 + PD * H;         // first clock showing the advanced line_index

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  raster_line_scanner_if bus ();

  raster_line_scanner dut (
    .clk   (clk),
    .reset (reset),
    .s_if  (bus)
  );

  always @(posedge clk)
    if (bus.fb_chipselect && bus.fb_clken) bus.fb_readdata <= bus.fb_address[7:0];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit sync;
    bit clr;
    bit exp_ovr;
    int exp_idx;
  } ovr_vec_t;

  ovr_vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return {23'd0, bus.fb_chipselect, bus.fb_clken, bus.fb_write, bus.fb_address,
            bus.laser_on, bus.laser_level, bus.frame_start, bus.line_index};
  endfunction

  function automatic logic [63:0] pack(input bit cs, input int addr, input bit on,
                                       input int lvl, input bit fs, input int idx);
    return {23'd0, cs, cs, 1'b0, 19'(addr), on, 8'(lvl), fs, 9'(idx)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_quick();
    bus.line_sync = 1'b1;
    tick(); tick();
    bus.line_sync = 1'b0;
    tick(); tick();
  endtask

  task automatic wait_addr(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (bus.fb_chipselect && bus.fb_address == 19'(target)) ok = 1'b1;
      else tick();
    end
  endtask

  // Pulse line_sync and check every output for a whole scanline from 3 clks after the pulse
  task automatic check_line(input int base, input int idx_in, input int idx_out,
                            input bit want_fs, input int fs_at);
    int  ncs, non, e_addr, e_lvl, e_idx;
    bit  e_cs, e_on, e_fs;
    ncs = 0;
    non = 0;
    bus.line_sync = 1'b1;
    for (int t = 1; t <= TON1 + 4; t++) begin
      tick();
      if (t == 2) bus.line_sync = 1'b0;
      if (t == fs_at) bus.frame_sync = 1'b1;
      if (t >= 3) begin
        e_cs   = (t >= T0) && (t <= TLI) && ((t - T0) % PD == 0);
        e_addr = e_cs ? base + (t - T0) / PD : 0;
        e_on   = (t >= TON0) && (t <= TON1);
        e_lvl  = e_on ? (base + (t - TON0) / PD) % 256 : 0;
        e_fs   = want_fs && (t == T0);
        e_idx  = (t < TADV) ? idx_in : idx_out;
        chk($sformatf("line base=%0d t=%0d", base, t), outs(),
            pack(e_cs, e_addr, e_on, e_lvl, e_fs, e_idx));
        ncs += int'(bus.fb_chipselect);
        non += int'(bus.laser_on);
      end
    end
    chk($sformatf("issue count base=%0d", base), 64'(ncs), 64'(H));
    chk($sformatf("laser_on clocks base=%0d", base), 64'(non), 64'(H * PD));
  endtask

  initial begin
    bit ok;
    int cnt;

    tbl[0] = '{sync: 1'b1, clr: 1'b0, exp_ovr: 1'b0, exp_idx: 0};
    tbl[1] = '{sync: 1'b1, clr: 1'b0, exp_ovr: 1'b1, exp_idx: 1};
    tbl[2] = '{sync: 1'b0, clr: 1'b1, exp_ovr: 1'b0, exp_idx: 1};
    tbl[3] = '{sync: 1'b1, clr: 1'b1, exp_ovr: 1'b1, exp_idx: 2};
    tbl[4] = '{sync: 1'b0, clr: 1'b0, exp_ovr: 1'b1, exp_idx: 2};
    tbl[5] = '{sync: 1'b0, clr: 1'b1, exp_ovr: 1'b0, exp_idx: 2};
    tbl[6] = '{sync: 1'b1, clr: 1'b0, exp_ovr: 1'b1, exp_idx: 3};

    reset             = 1'b1;
    bus.enable        = 1'b0;
    bus.line_sync     = 1'b0;
    bus.frame_sync    = 1'b0;
    bus.overrun_clear = 1'b0;
    #22;
    chk("reset outputs", outs(), 64'd0);
    chk("reset overrun", 64'(bus.line_overrun), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(bus.fb_chipselect);
    end
    chk("no issue before sync", 64'(cnt), 64'd0);

    // Single full line from line 0
    check_line(0, 0, 1, 1'b1, -1);

    // enable dropped at px=300 of line 1, then resume
    bus.line_sync = 1'b1;
    tick(); tick();
    bus.line_sync = 1'b0;
    wait_addr(640 + 300, ok);
    chk("reach px 300", 64'(ok), 64'd1);
    bus.enable = 1'b0;
    tick();
    chk("disable outputs", outs(), pack(1'b0, 0, 1'b0, 0, 1'b0, 1));
    tick(); tick(); tick();
    chk("disabled quiet", outs(), pack(1'b0, 0, 1'b0, 0, 1'b0, 1));
    bus.enable = 1'b1;
    tick(); tick();
    check_line(640, 1, 2, 1'b0, -1);

    // Asynchronous reset in the middle of line 2
    bus.line_sync = 1'b1;
    tick(); tick();
    bus.line_sync = 1'b0;
    wait_addr(1280 + 50, ok);
    chk("reach px 50", 64'(ok), 64'd1);
    tick();
    chk("laser on before reset", 64'(bus.laser_on), 64'd1);
    #2 reset = 1'b1;
    #1 chk("async reset outputs", outs(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(bus.fb_chipselect);
    end
    chk("no issue after reset", 64'(cnt), 64'd0);
    chk("index after reset", 64'(bus.line_index), 64'd0);

    // Overrun flag set/clear priority
    foreach (tbl[i]) begin
      bus.line_sync = tbl[i].sync;
      tick(); tick();
      bus.line_sync = 1'b0;
      bus.overrun_clear = tbl[i].clr;
      tick();
      bus.overrun_clear = 1'b0;
      chk($sformatf("ovr step %0d flag", i), 64'(bus.line_overrun), 64'(tbl[i].exp_ovr));
      chk($sformatf("ovr step %0d index", i), 64'(bus.line_index), 64'(tbl[i].exp_idx));
      tick();
    end
    bus.overrun_clear = 1'b1;
    tick();
    bus.overrun_clear = 1'b0;
    chk("flag cleared", 64'(bus.line_overrun), 64'd0);

    // Overrun at px=100 of line 3
    wait_addr(1920 + 100, ok);
    chk("reach px 100", 64'(ok), 64'd1);
    bus.line_sync = 1'b1;
    tick();
    chk("laser on pre-overrun", 64'(bus.laser_on), 64'd1);
    chk("flag pre-overrun", 64'(bus.line_overrun), 64'd0);
    tick();
    bus.line_sync = 1'b0;
    tick();
    chk("overrun laser off", {bus.laser_on, bus.laser_level}, 64'd0);
    chk("overrun flag", 64'(bus.line_overrun), 64'd1);
    chk("overrun index", 64'(bus.line_index), 64'd4);
    tick(); tick();
    chk("new line first issue", {bus.fb_chipselect, bus.fb_address}, {1'b1, 19'd2560});
    bus.overrun_clear = 1'b1;
    tick();
    bus.overrun_clear = 1'b0;
    chk("overrun cleared", 64'(bus.line_overrun), 64'd0);
    for (int i = 0; i < 3000 && bus.line_index == 9'd4; i++) tick();
    chk("aborted-restart line completes", 64'(bus.line_index), 64'd5);

    // Last line of the frame and wrap
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    for (int i = 0; i < 479; i++) pulse_quick();
    check_line(479 * 640, 479, 0, 1'b0, -1);
    check_line(0, 0, 1, 1'b1, -1);

    // frame_sync during line 200 restarts the frame after it
    for (int i = 0; i < 199; i++) pulse_quick();
    check_line(200 * 640, 200, 0, 1'b0, 100);
    bus.frame_sync = 1'b0;
    tick(); tick(); tick(); tick();
    check_line(0, 0, 1, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
